// File: rtl/tile_scheduler.sv
// Tile scheduler: walks the tile map row by row and hands each tile to the drawer.
// Optional build macro TILE_SKIP_EN: tiles with index 0 are skipped instead of drawn.
module tile_scheduler #(
    parameter int MAP_W       = 20,
    parameter int MAP_H       = 15,
    parameter int TILE_BYTES  = 192,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [8:0]  map_addr,
    output logic        map_rd,
    input  logic [3:0]  map_data,
    output logic        draw,
    output logic [11:0] tile_address,
    output logic [7:0]  x_pos,
    output logic [7:0]  y_pos,
    input  logic        drawer_active,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  tiles_drawn
);

    localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_MAP, ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE, DONE
    } state_t;

    state_t            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [8:0]        map_addr_q;
    logic [11:0]       tile_addr_q;
    logic [7:0]        x_pos_q;
    logic [7:0]        y_pos_q;
    logic [8:0]        tiles_q;
    logic [CNT_W-1:0]  ack_cnt_q;
    logic              map_rd_q;
    logic              draw_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              abort_pend_q;

    logic [11:0]       tile_addr_d;
    logic [7:0]        x_pos_d;
    logic [7:0]        y_pos_d;
    logic [CNT_W-1:0]  ack_cnt_d;
    logic              ack_timeout;
    logic              col_last;
    logic              row_last;
    logic              skip_tile;

    // map_data is consumed directly in WAIT_MAP, so the tile index needs no register of its own.
    assign tile_addr_d = 12'(map_data * TILE_BYTES);
    assign x_pos_d     = 8'({col_q, 3'b000});
    assign y_pos_d     = 8'({row_q, 3'b000});
    assign ack_cnt_d   = ack_cnt_q + CNT_W'(1);
    assign ack_timeout = (ack_cnt_d == CNT_W'(ACK_TIMEOUT));
    assign col_last    = (col_q == COL_W'(MAP_W - 1));
    assign row_last    = (row_q == ROW_W'(MAP_H - 1));

`ifdef TILE_SKIP_EN
    assign skip_tile = (map_data == 4'd0);
`else
    assign skip_tile = 1'b0;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            map_addr_q   <= '0;
            tile_addr_q  <= '0;
            x_pos_q      <= '0;
            y_pos_q      <= '0;
            tiles_q      <= '0;
            ack_cnt_q    <= '0;
            map_rd_q     <= 1'b0;
            draw_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            map_rd_q <= 1'b0;
            draw_q   <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        col_q        <= '0;
                        row_q        <= '0;
                        map_addr_q   <= '0;
                        tiles_q      <= '0;
                        error_q      <= 1'b0;
                        abort_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                        map_rd_q     <= 1'b1;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT_MAP;
                    end
                end
                WAIT_MAP: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tile_addr_q <= tile_addr_d;
                        x_pos_q     <= x_pos_d;
                        y_pos_q     <= y_pos_d;
                        if (skip_tile) begin
                            state_q <= ADVANCE;
                        end else begin
                            draw_q  <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The draw pulse is already on the wire this cycle, so it is counted even on abort.
                    tiles_q   <= tiles_q + 9'd1;
                    ack_cnt_q <= '0;
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (drawer_active) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        ack_cnt_q <= ack_cnt_d;
                        if (ack_timeout) begin
                            error_q <= 1'b1;
                            state_q <= ADVANCE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // The drawer owns the bus; an abort here waits for it to release first.
                    if (!drawer_active) begin
                        if (abort || abort_pend_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ADVANCE;
                        end
                    end else if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                ADVANCE: begin
                    if (abort || (col_last && row_last)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        map_addr_q <= map_addr_q + 9'd1;
                        map_rd_q   <= 1'b1;
                        state_q    <= FETCH;
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign map_addr     = map_addr_q;
    assign map_rd       = map_rd_q;
    assign draw         = draw_q;
    assign tile_address = tile_addr_q;
    assign x_pos        = x_pos_q;
    assign y_pos        = y_pos_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign tiles_drawn  = tiles_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: stimulus queues expected map reads, draws and done
// results; a negedge monitor pops and compares them as the DUT produces each event.
module tb_tile_scheduler;

    localparam int MAP_W       = 20;
    localparam int N_TILES     = 300;
    localparam int TILE_BYTES  = 192;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        drawer_active = 1'b0;
    logic [3:0]  map_data = 4'd0;
    logic [8:0]  map_addr;
    logic        map_rd;
    logic        draw;
    logic [11:0] tile_address;
    logic [7:0]  x_pos;
    logic [7:0]  y_pos;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  tiles_drawn;

    tile_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .map_addr     (map_addr),
        .map_rd       (map_rd),
        .map_data     (map_data),
        .draw         (draw),
        .tile_address (tile_address),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .drawer_active(drawer_active),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .tiles_drawn  (tiles_drawn)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] addr;
    } draw_t;

    typedef struct packed {
        logic [8:0] tiles;
        logic       err;
    } done_t;

    draw_t      exp_draw_q[$];
    logic [8:0] exp_addr_q[$];
    done_t      exp_done_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Map RAM: data appears after the read strobe and holds until the next read.
    logic [3:0] map_mem [0:511];
    always @(negedge clk) if (map_rd) map_data = map_mem[map_addr];

    // Drawer: acknowledges ack_delay cycles after a draw and stays busy active_len cycles.
    int          ack_delay  = 2;
    int          active_len = 4;
    bit          never_ack  = 1'b0;
    int unsigned fall_cyc   = 0;
    always begin
        @(negedge clk);
        if (draw && !never_ack && !reset) begin
            repeat (ack_delay) @(negedge clk);
            drawer_active = 1'b1;
            repeat (active_len) @(negedge clk);
            drawer_active = 1'b0;
            fall_cyc = cyc;
        end
    end

    int          draws_seen  = 0;
    int          maprd_seen  = 0;
    int          done_cnt    = 0;
    int unsigned done_cyc    = 0;
    draw_t       last_draw;
    draw_t       wrap_draw;
    logic [8:0]  wrap_addr;
    draw_t       d_exp;
    logic [8:0]  a_exp;
    done_t       n_exp;

    always @(negedge clk) begin
        if (!reset) begin
            if (map_rd) begin
                maprd_seen++;
                if (maprd_seen == 21) wrap_addr = map_addr;
                if (exp_addr_q.size() == 0) fail_evt("unexpected_map_rd");
                else begin
                    a_exp = exp_addr_q.pop_front();
                    check("map_addr", 32'(map_addr), 32'(a_exp));
                end
            end
            if (draw) begin
                draws_seen++;
                last_draw = '{x: x_pos, y: y_pos, addr: tile_address};
                if (draws_seen == 21) wrap_draw = last_draw;
                if (exp_draw_q.size() == 0) fail_evt("unexpected_draw");
                else begin
                    d_exp = exp_draw_q.pop_front();
                    check("draw_x_pos", 32'(x_pos), 32'(d_exp.x));
                    check("draw_y_pos", 32'(y_pos), 32'(d_exp.y));
                    check("draw_tile_address", 32'(tile_address), 32'(d_exp.addr));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done_q.size() == 0) fail_evt("unexpected_done");
                else begin
                    n_exp = exp_done_q.pop_front();
                    check("done_tiles_drawn", 32'(tiles_drawn), 32'(n_exp.tiles));
                    check("done_error", 32'(error), 32'(n_exp.err));
                    check("done_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_counters();
        draws_seen = 0;
        maprd_seen = 0;
        done_cnt   = 0;
    endtask

    // Reference walk: tile i sits at column i%MAP_W, row i/MAP_W.
    task automatic push_frame(input int n_tiles, output int n_draw);
        draw_t d;
        logic [3:0] idx;
        bit skip;
        n_draw = 0;
        for (int i = 0; i < n_tiles; i++) begin
            exp_addr_q.push_back(9'(i));
            idx  = map_mem[i];
            skip = 1'b0;
`ifdef TILE_SKIP_EN
            skip = (idx == 4'd0);
`endif
            if (!skip) begin
                d.x    = 8'((i % MAP_W) * 8);
                d.y    = 8'((i / MAP_W) * 8);
                d.addr = 12'(int'(idx) * TILE_BYTES);
                exp_draw_q.push_back(d);
                n_draw++;
            end
        end
    endtask

    task automatic push_done(input int tiles, input logic err);
        done_t e;
        e.tiles = 9'(tiles);
        e.err   = err;
        exp_done_q.push_back(e);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_draws(input int n, input int budget);
        int k = 0;
        while (draws_seen < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_draws_reached", 32'(draws_seen >= n), 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_done_reached", 32'(done_cnt >= n), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_draw"}, 32'(draw), 0);
        check({tag, "_map_rd"}, 32'(map_rd), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_map_addr"}, 32'(map_addr), 0);
        check({tag, "_tile_address"}, 32'(tile_address), 0);
        check({tag, "_x_pos"}, 32'(x_pos), 0);
        check({tag, "_y_pos"}, 32'(y_pos), 0);
        check({tag, "_tiles_drawn"}, 32'(tiles_drawn), 0);
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_left_map_rd"}, 32'(exp_addr_q.size()), 0);
        check({tag, "_left_draws"}, 32'(exp_draw_q.size()), 0);
        check({tag, "_left_done"}, 32'(exp_done_q.size()), 0);
    endtask

    initial begin
        int nd;
        int k;

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Full frame: every tile index 3, drawer holds the bus 200 cycles per tile.
        for (int i = 0; i < 512; i++) map_mem[i] = 4'd3;
        ack_delay  = 2;
        active_len = 200;
        never_ack  = 1'b0;
        reset_counters();
        push_frame(N_TILES, nd);
        push_done(300, 1'b0);
        start_frame();
        wait_draws(30, 8000);
        start_frame();
        wait_done(1, 70000);
        check("full_draws", 32'(draws_seen), 300);
        check("last_x_pos", 32'(last_draw.x), 152);
        check("last_y_pos", 32'(last_draw.y), 112);
        check("last_tile_address", 32'(last_draw.addr), 576);
        check("wrap_x_pos", 32'(wrap_draw.x), 0);
        check("wrap_y_pos", 32'(wrap_draw.y), 8);
        check("wrap_map_addr", 32'(wrap_addr), 20);
        tick();
        check("busy_after_frame", 32'(busy), 0);
        check_queues_empty("full");

        // Ack timeout: drawer never answers; indices cycle 0..15.
        for (int i = 0; i < 512; i++) map_mem[i] = 4'(i % 16);
        never_ack = 1'b1;
        reset_counters();
        push_frame(N_TILES, nd);
        push_done(nd, 1'b1);
        start_frame();
        wait_draws(1, 50);
        k = 0;
        while (!error && k < 40) begin
            tick();
            if (!error) k++;
        end
        check("ack_timeout_cycles", 32'(k), ACK_TIMEOUT);
        wait_done(1, 10000);
        repeat (3) tick();
        check("error_sticky_idle", 32'(error), 1);
        check_queues_empty("timeout");

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_no_done", 32'(done_cnt), 1);

        // Abort latched in WAIT_DONE of tile 5.
        for (int i = 0; i < 512; i++) map_mem[i] = 4'd5;
        never_ack  = 1'b0;
        ack_delay  = 2;
        active_len = 10;
        reset_counters();
        push_frame(5, nd);
        push_done(5, 1'b0);
        start_frame();
        check("error_cleared_on_start", 32'(error), 0);
        wait_draws(5, 300);
        k = 0;
        while (!drawer_active && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(1, 100);
        check("abort_done_after_release", 32'(done_cyc - fall_cyc), 1);
        repeat (6) tick();
        check("abort_no_tile6", 32'(draws_seen), 5);
        check_queues_empty("abort");

        // Reset in WAIT_ACK of tile 3, then a short restart from map_addr 0.
        for (int i = 0; i < 512; i++) map_mem[i] = 4'd9;
        never_ack = 1'b1;
        reset_counters();
        push_frame(N_TILES, nd);
        start_frame();
        wait_draws(3, 200);
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_draw", 32'(draw), 0);
        end
        check_all_zero("midreset");
        reset = 1'b0;
        exp_addr_q.delete();
        exp_draw_q.delete();
        exp_done_q.delete();
        reset_counters();
        tick();
        never_ack  = 1'b0;
        ack_delay  = 2;
        active_len = 3;
        push_frame(2, nd);
        push_done(2, 1'b0);
        start_frame();
        wait_draws(2, 100);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(1, 50);
        check_queues_empty("restart");

`ifdef TILE_SKIP_EN
        // Alternating 0/7 map: only the index-7 tiles are drawn.
        repeat (10) tick();
        for (int i = 0; i < 512; i++) map_mem[i] = (i % 2 == 0) ? 4'd0 : 4'd7;
        ack_delay  = 2;
        active_len = 4;
        reset_counters();
        push_frame(N_TILES, nd);
        push_done(150, 1'b0);
        start_frame();
        wait_done(1, 10000);
        check("skip_draws", 32'(draws_seen), 150);
        check("skip_last_tile_address", 32'(last_draw.addr), 1344);
        check_queues_empty("skip");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameter MAP_W, default 20: tile columns per frame (8-px tiles over a 160-px width).
REQ-002 Parameter MAP_H, default 15: tile rows per frame (8-px tiles over a 120-px height).
REQ-003 Parameter TILE_BYTES, default 192: ROM bytes per tile (64 pixels x 3 bytes, R/G/B).
REQ-004 Parameter ACK_TIMEOUT, default 16: maximum cycles to wait for drawer_active after a draw pulse.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin one frame walk; sampled only in IDLE.
REQ-008 abort  in  1  terminate the frame walk early.
REQ-009 map_addr  out  9  tile-map RAM read address, row*MAP_W+col.
REQ-010 map_rd  out  1  map read strobe; map_data is valid in the following cycle.
REQ-011 map_data  in  4  tile index returned by the map RAM.
REQ-012 draw  out  1  one-cycle request to the tile drawer.
REQ-013 tile_address  out  12  drawer tile base address, tile_index*TILE_BYTES.
REQ-014 x_pos  out  8  tile origin x, col*8.
REQ-015 y_pos  out  8  tile origin y, row*8.
REQ-016 drawer_active  in  1  high while the drawer owns the VGA bus.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at frame completion or abort.
REQ-019 error  out  1  sticky flag: an ACK timeout occurred.
REQ-020 tiles_drawn  out  9  number of draw pulses issued in the current frame.

Function
REQ-021 States: IDLE, FETCH, WAIT_MAP, ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE, DONE.
REQ-022 IDLE: when start=1, clear col, row, map_addr and tiles_drawn, then go to FETCH.
REQ-023 FETCH: map_rd=1 for exactly one cycle with map_addr stable; go to WAIT_MAP.
REQ-024 WAIT_MAP: latch map_data into tile_index; register tile_address, x_pos and y_pos; go to ISSUE.
REQ-025 ISSUE: draw=1 for exactly one cycle; increment tiles_drawn; clear the ack counter; go to WAIT_ACK.
REQ-026 tile_address, x_pos and y_pos are held stable from ISSUE until ADVANCE.
REQ-027 WAIT_ACK, drawer_active=1: go to WAIT_DONE.
REQ-028 WAIT_ACK, drawer_active=0: increment the ack counter; when the counter reaches ACK_TIMEOUT, set error and go to ADVANCE.
REQ-029 WAIT_DONE: when drawer_active=0, go to ADVANCE.
REQ-030 ADVANCE, normal step: col+1 and map_addr+1.
REQ-031 ADVANCE, col=MAP_W-1: col wraps to 0 and row+1.
REQ-032 ADVANCE, col=MAP_W-1 and row=MAP_H-1: go to DONE; otherwise go to FETCH.
REQ-033 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-034 abort=1 in FETCH, WAIT_MAP, ISSUE, WAIT_ACK or ADVANCE: go to DONE next cycle; no further draw pulse is issued.
REQ-035 abort=1 in WAIT_DONE: the abort is latched; the current tile completes; on drawer_active=0 the block goes to DONE instead of ADVANCE.
REQ-036 If abort and a state-transition condition are both true in the same cycle, abort wins, except as stated for WAIT_DONE.
REQ-037 start is ignored outside IDLE; abort is ignored in IDLE and DONE.
REQ-038 Arithmetic: tile_address = tile_index*TILE_BYTES truncated to 12 bits (15*192=2880 fits); x_pos and y_pos are {col,3'b000} and {row,3'b000}, zero-extended to 8 bits.
REQ-039 error clears only on reset or on an accepted start.

Reset
REQ-040 On reset=1 at a clock edge: state goes to IDLE; draw, map_rd, busy, done and error are 0; map_addr, tile_address, x_pos, y_pos, tiles_drawn, col, row and the ack counter are 0.
REQ-041 Reset mid-frame takes effect at that edge; no draw pulse follows while reset=1.

Configuration
REQ-042 Macro TILE_SKIP_EN, defined: a tile_index of 0 in WAIT_MAP goes directly to ADVANCE; no draw pulse; tiles_drawn is not incremented.
REQ-043 Macro TILE_SKIP_EN, undefined: index 0 is drawn like any other tile, with tile_address=0.

Verification
REQ-044 Full frame: map all index 3, drawer acks after 2 cycles and stays active 200 cycles -> 300 draw pulses, last pulse x_pos=152 y_pos=112 tile_address=576, done pulse, tiles_drawn=300, error=0.
REQ-045 Row wrap: at the 21st tile -> x_pos=0, y_pos=8, map_addr=20.
REQ-046 Ack timeout: drawer_active held 0 -> error=1 exactly 16 cycles after draw, the walk continues, and error persists until the next start.
REQ-047 Abort in WAIT_DONE during tile 5: no draw for tile 6; done is asserted 1 cycle after drawer_active falls; tiles_drawn=5.
REQ-048 Reset asserted in WAIT_ACK -> next cycle: busy=0, draw=0, all outputs 0; a subsequent start restarts at map_addr=0.
REQ-049 TILE_SKIP_EN defined, map alternating indices 0 and 7 -> 150 draw pulses, all with tile_address=1344, and tiles_drawn=150.
